// File: rtl/fp_ci_issuer.sv
// fp_ci_issuer: initiator for multi-cycle two-operand custom-instruction slaves.
//
// Operand pairs arrive on a valid/ready stream and are buffered in a small FIFO.
// Each pair is issued to the slave as a one-cycle ci_start pulse, with ci_dataa and
// ci_datab held stable until ci_done returns. The captured result is then presented on
// a valid/ready output stream. Only one operation is in flight at a time.
//
// Optional feature macro: CI_TIMEOUT_EN. When it is defined, an operation that
// sees no ci_done for TIMEOUT wait cycles is aborted. It then completes with a qNaN
// result and out_timeout=1. When undefined, WAIT holds indefinitely and out_timeout is 0.
//
// Ports:
//   clk, reset_n           clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready      upstream handshake; in_dataa/in_datab operand pair
//   ci_start               one-cycle issue pulse; ci_dataa/ci_datab operands to slave
//   ci_done/ci_result      slave completion strobe and result
//   out_valid/out_ready    downstream handshake; out_result, out_timeout payload
//   busy                   operation in progress or FIFO non-empty
module fp_ci_issuer #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_dataa,
   input  logic [31:0] in_datab,
   output logic        ci_start,
   output logic [31:0] ci_dataa,
   output logic [31:0] ci_datab,
   input  logic        ci_done,
   input  logic [31:0] ci_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_result,
   output logic        out_timeout,
   output logic        busy
);

   localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("FIFO_DEPTH must be a power of two and at least 2");
   end
   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
      $error("TIMEOUT must be in 1..65535");
   end

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

   // ---------------------------------------------------------------------------
   // Operand FIFO
   // ---------------------------------------------------------------------------
   logic [63:0]     mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;
   logic            in_ready_q;
   logic            push, pop;

   state_e state_q, state_d;

   assign push = in_valid && in_ready_q;
   assign pop  = (state_q == StIssue);

   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {in_dataa, in_datab};
      end
   end

   // Pointers are exactly PtrW bits wide, so the increment wraps modulo FIFO_DEPTH.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         in_ready_q <= 1'b1;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q    <= count_d;
         // Registered full flag: a pop in the same cycle does not reopen the input.
         in_ready_q <= (count_d != FullCnt);
      end
   end

   // ---------------------------------------------------------------------------
   // Issue FSM
   // ---------------------------------------------------------------------------
   logic        ci_start_q, ci_start_d;
   logic [31:0] ci_dataa_q, ci_dataa_d;
   logic [31:0] ci_datab_q, ci_datab_d;
   logic        out_valid_q, out_valid_d;
   logic [31:0] out_result_q, out_result_d;
   logic        out_timeout_q, out_timeout_d;

`ifdef CI_TIMEOUT_EN
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
`endif

   always_comb begin
      state_d       = state_q;
      ci_start_d    = 1'b0;
      ci_dataa_d    = ci_dataa_q;
      ci_datab_d    = ci_datab_q;
      out_valid_d   = out_valid_q;
      out_result_d  = out_result_q;
      out_timeout_d = out_timeout_q;
`ifdef CI_TIMEOUT_EN
      tmo_cnt_d     = tmo_cnt_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (count_q != '0) begin
               // Operands latch on entry to ISSUE and stay put through WAIT.
               state_d    = StIssue;
               ci_start_d = 1'b1;
               ci_dataa_d = mem_q[rd_ptr_q][63:32];
               ci_datab_d = mem_q[rd_ptr_q][31:0];
            end
         end
         StIssue: begin
            state_d = StWait;
`ifdef CI_TIMEOUT_EN
            tmo_cnt_d = '0;
`endif
         end
         StWait: begin
            if (ci_done) begin
               state_d       = StHold;
               out_valid_d   = 1'b1;
               out_result_d  = ci_result;
               out_timeout_d = 1'b0;
`ifdef CI_TIMEOUT_EN
            end else if (tmo_cnt_q == 16'(TIMEOUT - 1)) begin
               // This is the TIMEOUT-th wait cycle without a response: abort with qNaN.
               state_d       = StHold;
               out_valid_d   = 1'b1;
               out_result_d  = 32'h7FC0_0000;
               out_timeout_d = 1'b1;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 16'd1;
`endif
            end
         end
         StHold: begin
            if (out_ready) begin
               state_d     = StIdle;
               out_valid_d = 1'b0;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= StIdle;
         ci_start_q    <= 1'b0;
         ci_dataa_q    <= '0;
         ci_datab_q    <= '0;
         out_valid_q   <= 1'b0;
         out_result_q  <= '0;
         out_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ci_start_q    <= ci_start_d;
         ci_dataa_q    <= ci_dataa_d;
         ci_datab_q    <= ci_datab_d;
         out_valid_q   <= out_valid_d;
         out_result_q  <= out_result_d;
         out_timeout_q <= out_timeout_d;
      end
   end

`ifdef CI_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tmo_cnt_q <= '0;
      end else begin
         tmo_cnt_q <= tmo_cnt_d;
      end
   end
   assign out_timeout = out_timeout_q;
`else
   assign out_timeout = 1'b0;
`endif

   assign in_ready   = in_ready_q;
   assign ci_start   = ci_start_q;
   assign ci_dataa   = ci_dataa_q;
   assign ci_datab   = ci_datab_q;
   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign busy       = (state_q != StIdle) || (count_q != '0);

endmodule

// File: tb/tb_fp_ci_issuer.sv
// Randomized self-checking bench for fp_ci_issuer. A behavioural model tracks the
// queued operand pairs and which phase the single in-flight operation is in. It
// predicts every output each cycle, and a simple slave model answers ci_start.
module tb_fp_ci_issuer;

   localparam int unsigned Depth = 4;
   localparam int unsigned Tmo   = 20;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_dataa = '0, in_datab = '0;
   logic        ci_start;
   logic [31:0] ci_dataa, ci_datab;
   logic        ci_done = 1'b0;
   logic [31:0] ci_result = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_result;
   logic        out_timeout;
   logic        busy;

   fp_ci_issuer #(.FIFO_DEPTH(Depth), .TIMEOUT(Tmo)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_dataa   (in_dataa),
      .in_datab   (in_datab),
      .ci_start   (ci_start),
      .ci_dataa   (ci_dataa),
      .ci_datab   (ci_datab),
      .ci_done    (ci_done),
      .ci_result  (ci_result),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_timeout(out_timeout),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
   } pair_t;
   typedef enum {PIdle, PIssue, PWait, PHold} phase_e;

   int checks = 0;
   int failures = 0;

   // Model state
   pair_t       fifo_m[$];
   pair_t       send_q[$];
   pair_t       cur;
   phase_e      phase = PIdle;
   int          wcnt = 0;
   logic [31:0] exp_res = '0;
   logic        exp_to = 1'b0;
   int          n_push = 0, n_res = 0, n_to = 0, n_start = 0;
   logic [31:0] last_res = '0;
   logic        saw_full = 1'b0;

   // Stimulus knobs
   int gate_pct = 100, ready_pct = 100, lat_min = 1, lat_max = 1;
   bit spur_en = 1'b0;
   int silent_ops = 0;
   int slv_cnt = 0;
   logic [31:0] slv_res = '0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Slave behaviour: a fixed answer for the directed case, a mix of operands otherwise.
   function automatic logic [31:0] slave_fn(input logic [31:0] a, input logic [31:0] b);
      if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
      return a ^ {b[15:0], b[31:16]} ^ 32'h1234_5678;
   endfunction

   task automatic step();
      bit push;
      @(negedge clk);
      // Compare DUT state after the last edge with the model.
      check_eq("in_ready", 32'(in_ready), 32'(fifo_m.size() != Depth));
      check_eq("busy", 32'(busy), 32'(phase != PIdle || fifo_m.size() != 0));
      check_eq("ci_start", 32'(ci_start), 32'(phase == PIssue));
      if (phase == PIssue && fifo_m.size() > 0) begin
         check_eq("issue_a", ci_dataa, fifo_m[0].a);
         check_eq("issue_b", ci_datab, fifo_m[0].b);
      end
      if (phase == PWait) begin
         check_eq("hold_a", ci_dataa, cur.a);
         check_eq("hold_b", ci_datab, cur.b);
      end
      check_eq("out_valid", 32'(out_valid), 32'(phase == PHold));
      if (phase == PHold) begin
         check_eq("out_result", out_result, exp_res);
         check_eq("out_timeout", 32'(out_timeout), 32'(exp_to));
      end
      if (!in_ready) saw_full = 1'b1;
      if (ci_start) n_start++;

      // Slave model
      ci_done   = 1'b0;
      ci_result = $urandom;
      if (ci_start) begin
         slv_res = slave_fn(ci_dataa, ci_datab);
         if (silent_ops > 0) begin
            silent_ops--;
            slv_cnt = 0;
         end else begin
            slv_cnt = $urandom_range(lat_max, lat_min);
         end
      end else if (slv_cnt > 0) begin
         slv_cnt--;
         if (slv_cnt == 0) begin
            ci_done   = 1'b1;
            ci_result = slv_res;
         end
      end else if (spur_en && phase != PWait && $urandom_range(3) == 0) begin
         ci_done = 1'b1;
      end

      // Upstream/downstream drive
      in_valid = (send_q.size() > 0) && ($urandom_range(99) < gate_pct);
      if (send_q.size() > 0) begin
         in_dataa = send_q[0].a;
         in_datab = send_q[0].b;
      end
      out_ready = ($urandom_range(99) < ready_pct);

      // Model: what the coming edge does
      push = in_valid && (fifo_m.size() != Depth);
      case (phase)
         PIdle: if (fifo_m.size() != 0) phase = PIssue;
         PIssue: begin
            cur     = fifo_m.pop_front();
            phase   = PWait;
            wcnt    = 0;
         end
         PWait: begin
            if (ci_done) begin
               phase   = PHold;
               exp_res = slave_fn(cur.a, cur.b);
               exp_to  = 1'b0;
            end else begin
               wcnt++;
`ifdef CI_TIMEOUT_EN
               if (wcnt == Tmo) begin
                  phase   = PHold;
                  exp_res = 32'h7FC0_0000;
                  exp_to  = 1'b1;
               end
`endif
            end
         end
         PHold: begin
            if (out_ready) begin
               phase    = PIdle;
               last_res = exp_res;
               n_res++;
               if (exp_to) n_to++;
            end
         end
         default: phase = PIdle;
      endcase
      if (push) begin
         fifo_m.push_back(send_q.pop_front());
         n_push++;
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check_eq({tag, "_ci_start"}, 32'(ci_start), 32'd0);
      check_eq({tag, "_ci_dataa"}, ci_dataa, 32'd0);
      check_eq({tag, "_ci_datab"}, ci_datab, 32'd0);
      check_eq({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      check_eq({tag, "_out_result"}, out_result, 32'd0);
      check_eq({tag, "_out_timeout"}, 32'(out_timeout), 32'd0);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset_n = 1'b0;
      in_valid  = 1'b0;
      ci_done   = 1'b0;
      out_ready = 1'b0;
      #1 check_reset_vals("rst");
      fifo_m.delete();
      send_q.delete();
      phase   = PIdle;
      slv_cnt = 0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic drain(input string tag, input int bound);
      int i;
      for (i = 0; i < bound; i++) begin
         if (phase == PIdle && fifo_m.size() == 0 && send_q.size() == 0) break;
         step();
      end
      check_eq({tag, "_drained"}, 32'(i < bound), 32'd1);
   endtask

   initial begin
      int base_res, base_start;
      pair_t p;

      // Reset values
      repeat (3) @(negedge clk);
      check_reset_vals("init");
      reset_n = 1'b1;

      // Single directed op, slave latency 5
      lat_min = 5; lat_max = 5; ready_pct = 100;
      base_start = n_start;
      p.a = 32'h3F80_0000; p.b = 32'h4000_0000;
      send_q.push_back(p);
      drain("single", 40);
      check_eq("single_starts", 32'(n_start - base_start), 32'd1);
      check_eq("single_res", last_res, 32'h4040_0000);

      // Spurious done while idle
      spur_en = 1'b1;
      repeat (10) step();
      check_eq("spur_no_res", 32'(n_res), 32'd1);

      // Back-pressure and output stall (spurious done also hits HOLD)
      lat_min = 2; lat_max = 2; ready_pct = 0; saw_full = 1'b0;
      base_res = n_res;
      for (int i = 0; i < Depth + 2; i++) begin
         p.a = $urandom; p.b = $urandom;
         send_q.push_back(p);
      end
      repeat (25) step();
      check_eq("bp_full", 32'(saw_full), 32'd1);
      check_eq("bp_stalled", 32'(n_res - base_res), 32'd0);
      ready_pct = 100;
      drain("bp", 200);
      check_eq("bp_count", 32'(n_res - base_res), Depth + 2);

      // Randomized traffic
      gate_pct = 60; ready_pct = 60; lat_min = 1; lat_max = 6;
      for (int i = 0; i < 60; i++) begin
         p.a = $urandom; p.b = $urandom;
         send_q.push_back(p);
      end
      drain("rand", 2000);
      gate_pct = 100; ready_pct = 100; spur_en = 1'b0;

`ifdef CI_TIMEOUT_EN
      // First op gets no response; the second must still issue normally.
      base_res = n_res;
      silent_ops = 1; lat_min = 3; lat_max = 3;
      for (int i = 0; i < 2; i++) begin
         p.a = $urandom; p.b = $urandom;
         send_q.push_back(p);
      end
      drain("tmo", 200);
      check_eq("tmo_count", 32'(n_to), 32'd1);
      check_eq("tmo_total", 32'(n_res - base_res), 32'd2);
`endif

      // Reset in WAIT with two pairs queued
      lat_min = 30; lat_max = 30;
      for (int i = 0; i < 3; i++) begin
         p.a = $urandom; p.b = $urandom;
         send_q.push_back(p);
      end
      begin
         int i;
         for (i = 0; i < 40; i++) begin
            if (phase == PWait && fifo_m.size() == 2) break;
            step();
         end
         check_eq("rw_reached", 32'(i < 40), 32'd1);
      end
      do_reset();
      base_start = n_start;
      repeat (10) step();
      check_eq("rw_no_start", 32'(n_start - base_start), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
